// File: rtl/adat_tx_stream.sv
// ADAT optical-link transmitter: builds 256-bit frames from buffered samples and drives an NRZI line.
// Latency: a sample accepted at edge N is sent in the first frame load after N; frames run back to back while enable is high.
// Backpressure: one-entry holding buffer, sample_ready = buffer empty; an empty buffer at load repeats the last audio and pulses underrun.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   enable                 run request (level); a frame in progress always completes
//   timecode, midi, smux   user bits, captured at each frame load
//   samples, sample_valid  flat channel vector (ch0 in the low bits) and its valid
//   sample_ready           holding buffer empty
//   frame_start, underrun  one-cycle pulses following each frame load
//   busy                   high while in RUN
//   bitstream_out          NRZI-encoded ADAT line
module adat_tx_stream #(
    parameter int OVERSAMPLE = 8,
    parameter int NUM_CH     = 8,
    parameter int SAMPLE_W   = 24
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       timecode,
    input  logic                       midi,
    input  logic                       smux,
    input  logic [NUM_CH*SAMPLE_W-1:0] samples,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic                       frame_start,
    output logic                       underrun,
    output logic                       busy,
    output logic                       bitstream_out
);

    localparam int TW = $clog2(OVERSAMPLE);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                     state, state_nx;
    logic [TW-1:0]              tick;
    logic [7:0]                 bit_idx;
    logic [255:0]               shreg;
    logic [NUM_CH*SAMPLE_W-1:0] hold_dat;
    logic                       hold_full;
    logic [191:0]               last_audio;
    logic [191:0]               fmt_audio;
    logic [191:0]               audio_sel;
    logic [255:0]               frame;
    logic                       tick_last;
    logic                       frame_end;
    logic                       load;
    logic                       bit_edge;
    logic                       capture;

    assign tick_last    = (tick == TW'(OVERSAMPLE - 1));
    assign frame_end    = tick_last && (bit_idx == 8'd255);
    assign bit_edge     = (state == RUN) && tick_last && (bit_idx != 8'd255);
    assign capture      = sample_valid && !hold_full;
    assign sample_ready = ~hold_full;
    assign busy         = (state == RUN);

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (frame_end) begin
                    if (enable) load = 1'b1;
                    else        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Each sample is MSB-aligned in its 24-bit slot with zero LSBs; slot 0 is sent first.
    always_comb begin
        logic [23:0] slot;
        fmt_audio = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            slot                 = '0;
            slot[SAMPLE_W-1:0]   = hold_dat[c*SAMPLE_W +: SAMPLE_W];
            fmt_audio[191-24*c -: 24] = slot << (24 - SAMPLE_W);
        end
    end

    // A full buffer is consumed by this load; an empty one repeats the previous audio.
    assign audio_sel = hold_full ? fmt_audio : last_audio;

    // Frame bit 0 sits at frame[255] so the register can shift left MSB first.
    always_comb begin
        frame          = '0;
        frame[255:240] = {1'b1, 10'b0, 1'b1, timecode, midi, smux, 1'b0};
        for (int g = 0; g < 48; g++) begin
            frame[239-5*g -: 5] = {1'b1, audio_sel[191-4*g -: 4]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            tick          <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            hold_dat      <= '0;
            hold_full     <= 1'b0;
            last_audio    <= '0;
            frame_start   <= 1'b0;
            underrun      <= 1'b0;
            bitstream_out <= 1'b0;
        end else begin
            state       <= state_nx;
            frame_start <= load;
            underrun    <= load && !hold_full;

            if (load) begin
                tick    <= '0;
                bit_idx <= '0;
            end else if (state == RUN) begin
                if (tick_last) begin
                    tick    <= '0;
                    bit_idx <= bit_idx + 8'd1;
                end else begin
                    tick <= tick + TW'(1);
                end
            end else begin
                tick    <= '0;
                bit_idx <= '0;
            end

            // NRZI: a 1 toggles the line, a 0 holds it.
            if (load) begin
                shreg         <= frame;
                last_audio    <= audio_sel;
                bitstream_out <= bitstream_out ^ frame[255];
            end else if (bit_edge) begin
                shreg         <= shreg << 1;
                bitstream_out <= bitstream_out ^ shreg[254];
            end

            // Capture only happens into an empty buffer, so a same-edge load has already
            // taken the repeat path and the new data waits for the next frame.
            if (capture) begin
                hold_dat  <= samples;
                hold_full <= 1'b1;
            end else if (load && hold_full) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adat_tx_stream.sv
// Bench for adat_tx_stream: two instances (8ch x 24b and 2ch x 16b) share control stimulus.
// A frame-level reference model predicts per-cycle control outputs and the line, and queues decoded frames.
// A negedge monitor decodes each NRZI frame after frame_start and compares it with the queued frame.
module tb_adat_tx_stream;

    localparam int OS = 8;
    localparam int FR = 256 * OS;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic timecode = 1'b0;
    logic midi = 1'b0;
    logic smux = 1'b0;
    logic sample_valid = 1'b0;
    logic [23:0] s_in [8];
    logic [191:0] samples1;
    logic [31:0]  samples2;

    logic rdy1, fs1, ur1, busy1, line1;
    logic rdy2, fs2, ur2, busy2, line2;

    always #5 clk = ~clk;

    always_comb begin
        samples1 = '0;
        samples2 = '0;
        for (int c = 0; c < 8; c++) samples1[c*24 +: 24] = s_in[c];
        for (int c = 0; c < 2; c++) samples2[c*16 +: 16] = s_in[c][23:8];
    end

    adat_tx_stream #(.OVERSAMPLE(OS), .NUM_CH(8), .SAMPLE_W(24)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .timecode(timecode),
        .midi(midi), .smux(smux), .samples(samples1), .sample_valid(sample_valid),
        .sample_ready(rdy1), .frame_start(fs1), .underrun(ur1), .busy(busy1),
        .bitstream_out(line1));

    adat_tx_stream #(.OVERSAMPLE(OS), .NUM_CH(2), .SAMPLE_W(16)) dut2 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .timecode(timecode),
        .midi(midi), .smux(smux), .samples(samples2), .sample_valid(sample_valid),
        .sample_ready(rdy2), .frame_start(fs2), .underrun(ur2), .busy(busy2),
        .bitstream_out(line2));

    int checks = 0;
    int errors = 0;
    logic end_chk = 1'b0;

    // ---------------- reference model ----------------
    logic [255:0] q1[$];
    logic [255:0] q2[$];
    logic [23:0]  m_buf [8];
    logic [23:0]  m_last [8];
    logic [255:0] m_frame1 = '0, m_frame2 = '0;
    logic m_run = 0, m_full = 0, m_fs = 0, m_ur = 0, m_line1 = 0, m_line2 = 0;
    int   m_cnt = 0;

    // Expected frame with v[k] = k-th transmitted bit. cfg 1: 8ch x 24b, cfg 2: 2ch x 16b.
    function automatic logic [255:0] build(input logic tc, input logic md, input logic sm,
                                           input logic [23:0] raw [8], input int cfg);
        logic [255:0] v;
        logic [23:0]  slot [8];
        int j, ch, r, p;
        for (int c = 0; c < 8; c++) begin
            if (cfg == 1)   slot[c] = raw[c];
            else if (c < 2) slot[c] = 24'((raw[c] / 256) * 256);
            else            slot[c] = 24'd0;
        end
        for (int k = 0; k < 256; k++) begin
            if (k == 0)       v[k] = 1'b1;
            else if (k < 11)  v[k] = 1'b0;
            else if (k == 11) v[k] = 1'b1;
            else if (k == 12) v[k] = tc;
            else if (k == 13) v[k] = md;
            else if (k == 14) v[k] = sm;
            else if (k == 15) v[k] = 1'b0;
            else begin
                j  = k - 16;
                ch = j / 30;
                r  = j % 30;
                p  = r % 5;
                if (p == 0) v[k] = 1'b1;
                else        v[k] = slot[ch][23 - 4*(r/5) - (p-1)];
            end
        end
        return v;
    endfunction

    initial begin
        logic ld, cap;
        for (int c = 0; c < 8; c++) begin m_buf[c] = '0; m_last[c] = '0; end
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_run = 0; m_cnt = 0; m_full = 0; m_fs = 0; m_ur = 0;
                m_line1 = 0; m_line2 = 0;
                for (int c = 0; c < 8; c++) begin m_buf[c] = '0; m_last[c] = '0; end
                q1.delete();
                q2.delete();
            end else begin
                ld   = enable && (!m_run || m_cnt == FR - 1);
                cap  = sample_valid && !m_full;
                m_fs = ld;
                m_ur = ld && !m_full;
                if (ld) begin
                    if (m_full) begin
                        m_last = m_buf;
                        m_full = 0;
                    end
                    m_frame1 = build(timecode, midi, smux, m_last, 1);
                    m_frame2 = build(timecode, midi, smux, m_last, 2);
                    q1.push_back(m_frame1);
                    q2.push_back(m_frame2);
                    m_line1 = m_line1 ^ m_frame1[0];
                    m_line2 = m_line2 ^ m_frame2[0];
                    m_run = 1;
                    m_cnt = 0;
                end else if (m_run) begin
                    if (m_cnt == FR - 1) begin
                        m_run = 0;
                        m_cnt = 0;
                    end else begin
                        m_cnt = m_cnt + 1;
                        if (m_cnt % OS == 0) begin
                            m_line1 = m_line1 ^ m_frame1[m_cnt / OS];
                            m_line2 = m_line2 ^ m_frame2[m_cnt / OS];
                        end
                    end
                end
                if (cap) begin
                    m_buf  = s_in;
                    m_full = 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        logic dec = 0, gl1 = 0, gl2 = 0, prev1 = 0, prev2 = 0, lv1 = 0, lv2 = 0, end_done = 0;
        logic [255:0] d1 = '0, d2 = '0;
        int off = 0, k;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_line",  256'(line1), 256'(0));
                chk("rst_ready", 256'(rdy1),  256'(1));
                chk("rst_busy",  256'(busy1), 256'(0));
                chk("rst_fs",    256'(fs1),   256'(0));
                chk("rst_ur",    256'(ur1),   256'(0));
                chk("rst_line2", 256'(line2), 256'(0));
                dec = 0; prev1 = 0; prev2 = 0;
            end else begin
                chk("frame_start", 256'({fs1, fs2}),     256'({m_fs, m_fs}));
                chk("underrun",    256'({ur1, ur2}),     256'({m_ur, m_ur}));
                chk("busy",        256'({busy1, busy2}), 256'({m_run, m_run}));
                chk("ready",       256'({rdy1, rdy2}),   256'({!m_full, !m_full}));
                chk("line",        256'({line1, line2}), 256'({m_line1, m_line2}));
                if (fs1) begin
                    dec = 1; off = 0; lv1 = prev1; lv2 = prev2; gl1 = 0; gl2 = 0;
                end
                if (dec) begin
                    if (off % OS == 0) begin
                        k = off / OS;
                        d1[k] = line1 ^ lv1;
                        d2[k] = line2 ^ lv2;
                        lv1 = line1;
                        lv2 = line2;
                        if (k == 255) begin
                            dec = 0;
                            chk("glitch", 256'({gl1, gl2}), 256'(0));
                            if (q1.size() == 0) begin
                                chk("frame_q", 256'(0), 256'(1));
                            end else begin
                                chk("frame1", d1, q1.pop_front());
                                chk("frame2", d2, q2.pop_front());
                            end
                        end
                    end else begin
                        if (line1 != lv1) gl1 = 1;
                        if (line2 != lv2) gl2 = 1;
                    end
                    off++;
                end
                prev1 = line1;
                prev2 = line2;
            end
            if (end_chk && !end_done) begin
                chk("frames_left", 256'(q1.size()), 256'(0));
                end_done = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_samples();
        for (int c = 0; c < 8; c++) s_in[c] = '0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
    endtask

    initial begin
        clear_samples();
        cyc(3);
        reset_n = 1'b1;
        cyc(2);

        // Single frame with ch0 = ABCDEF, user bits 1/0/1; enable dropped at bit 100.
        s_in[0] = 24'hABCDEF;
        timecode = 1'b1; midi = 1'b0; smux = 1'b1;
        sample_valid = 1'b1;
        cyc(1);
        sample_valid = 1'b0;
        cyc(2);
        enable = 1'b1;
        cyc(100 * OS);
        enable = 1'b0;
        cyc(FR);
        // Restart from IDLE: immediate load, buffer empty so audio repeats.
        enable = 1'b1;
        cyc(1);
        enable = 1'b0;
        cyc(FR + 10);

        // Underrun from reset: zero audio, underrun on every load.
        pulse_reset();
        timecode = 1'b0; smux = 1'b0; midi = 1'b1;
        enable = 1'b1;
        cyc(2 * FR - 10);
        enable = 1'b0;
        cyc(FR);

        // Repeat/hold: ch3 = 123456, ch1 = 8001FF (second instance sees 8001 -> 800100).
        clear_samples();
        s_in[3] = 24'h123456;
        s_in[1] = 24'h8001FF;
        sample_valid = 1'b1;
        cyc(1);
        sample_valid = 1'b0;
        enable = 1'b1;
        cyc(2 * FR - 10);
        enable = 1'b0;
        cyc(FR);

        // Capture and load on the same edge.
        for (int c = 0; c < 8; c++) s_in[c] = 24'($urandom);
        sample_valid = 1'b1;
        enable = 1'b1;
        cyc(1);
        sample_valid = 1'b0;
        cyc(2 * FR - 10);
        enable = 1'b0;
        cyc(FR);

        // Randomised pushes and user bits over continuous frames.
        enable = 1'b1;
        for (int i = 0; i < 4 * FR; i++) begin
            sample_valid = ($urandom_range(0, 63) == 0);
            for (int c = 0; c < 8; c++) s_in[c] = 24'($urandom);
            if ($urandom_range(0, 96) == 0) timecode = ~timecode;
            if ($urandom_range(0, 96) == 0) midi = ~midi;
            if ($urandom_range(0, 96) == 0) smux = ~smux;
            cyc(1);
        end
        enable = 1'b0;
        sample_valid = 1'b0;
        cyc(FR + 10);

        // Reset mid-frame: outputs must clear before the next active edge.
        enable = 1'b1;
        cyc(700);
        @(posedge clk);
        #1 reset_n = 1'b0;
        enable = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        cyc(3);

        end_chk = 1'b1;
        cyc(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adat_tx_stream.md
Name: adat_tx_stream

Overview:
Parametrised ADAT optical-link transmitter that replaces the single-shot, externally framed transmitter.
- Generates its own 256-bit frame timing.
- Accepts channel samples through a valid/ready holding buffer.
- Supports 1..8 channels and 1..24-bit samples.
- Reports underruns.
- Drives the NRZI bitstream to the optical transmitter pin from the mixer output stage.

Parameters:
OVERSAMPLE, 8, clocks per ADAT bit period (>=2); frame period = 256*OVERSAMPLE clocks
NUM_CH, 8, channels carried (1..8); slots NUM_CH..7 transmit zero
SAMPLE_W, 24, input sample width (1..24); MSB-aligned into 24-bit slot, LSBs zero-filled

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  run request; level-sensitive
timecode  input  1  user bit 0, captured at frame load
midi  input  1  user bit 1, captured at frame load
smux  input  1  user bit 2, captured at frame load
samples  input  NUM_CH*SAMPLE_W  flat sample vector; channel c at bits [(c+1)*SAMPLE_W-1 : c*SAMPLE_W]
sample_valid  input  1  samples valid
sample_ready  output  1  holding buffer empty
frame_start  output  1  one-cycle pulse on each frame load
underrun  output  1  one-cycle pulse when a frame loads with the holding buffer empty
busy  output  1  high in RUN state
bitstream_out  output  1  NRZI-encoded ADAT stream

Behaviour:
- Reset (async, reset_n low):
  - All outputs are 0 except sample_ready, which is 1.
  - Shift register, holding buffer, tick and bit counters are cleared; state goes to IDLE.
  - Reset mid-frame aborts immediately; the line stays low.
- Frame format, MSB first, 256 bits:
  - 1 followed by ten 0s (sync).
  - 1, timecode, midi, smux, 0.
  - Per channel 0..7: six nibbles of the 24-bit slot, each preceded by a 1.
- Counters:
  - tick runs 0..OVERSAMPLE-1 and wraps; bit increments when tick wraps.
  - bit runs 0..255 and wraps.
- States:
  - IDLE: counters held at 0; bitstream_out holds its last level.
    - Transition to RUN on the first edge with enable=1; that edge performs a frame load.
  - RUN: when tick==OVERSAMPLE-1 and bit==255, the next edge performs a frame load if enable=1. Otherwise the state goes to IDLE and no load occurs.
    - Deasserting enable mid-frame always completes the current frame.
- Frame load edge:
  - Shift register takes the assembled frame.
  - tick and bit go to 0.
  - frame_start pulses.
  - bitstream_out toggles, since frame bit 255 is always 1.
- Bit edges: at every edge with tick==OVERSAMPLE-1 and bit!=255, the shift register shifts left by one and bitstream_out XORs with the new MSB. A 1 toggles the line; a 0 holds it.
- Holding buffer (one entry):
  - sample_ready = ~buf_full, purely from a register.
  - Capture when sample_valid && sample_ready.
  - On frame load with buf_full: frame uses the buffer contents and buf_full clears.
  - On frame load with buffer empty: the previous frame's audio slots are repeated and underrun pulses. The first frame after reset with an empty buffer sends zeros and pulses underrun.
  - Capture and load on the same edge: a capture only occurs when the buffer is empty, so that frame underruns. The newly captured data is used in the next frame, never merged into the current one.
- Sample formatting: slot = {sample, (24-SAMPLE_W) zeros}; the sign bit is not extended into the LSBs.
- Latency: a sample accepted at edge N appears in the first frame load strictly after N.

Test Plan:
- Reset value check: assert reset_n=0 mid-frame (OVERSAMPLE=8) -> bitstream_out=0, sample_ready=1, busy=0, frame_start=0, underrun=0 within the same cycle, before any clock edge.
- Single frame, defaults: push ch0=24'hABCDEF, others 0, user bits 1/0/1, then enable=1. The NRZI-decoded 256 bits must read:
  - sync 1000_0000_000;
  - user field 11010;
  - ch0 field 11010_11011_11100_11101_11110_11111;
  - zero channels all 10000 per nibble.
  - No line transition for 10*8=80 clocks after the first toggle.
- Underrun: enable with no sample ever pushed -> underrun pulses coincident with every frame_start (one every 2048 clocks); audio slots are 0; sample_ready stays 1.
- Repeat/hold: push a sample with ch3=0x123456, run 2 frames without pushing -> second frame repeats ch3=0x123456, underrun=1 on the second load only.
- Width/channels: NUM_CH=2, SAMPLE_W=16, push ch1=16'h8001 -> slot 1 reads 24'h800100; slots 2..7 read zero.
- Enable drop: deassert enable at bit 100 -> frame completes all 256 bits, no frame_start follows, busy falls on the cycle after bit 255 ends, and the line holds its level. Reassert enable -> frame_start pulses on the next edge.
